// File: rtl/vx_sched_pkg.sv
// Shared field layout for warp-schedule entries: widths, offsets and pack/unpack helpers.
// Entries are packed MSB->LSB as {uuid, wid, tmask, PC}.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

package vx_sched_pkg;

   localparam int THREAD_CNT_D = `NUM_THREADS;
   localparam int UUID_W_D     = `UUID_WIDTH;
   localparam int NW_W_D       = `NW_WIDTH;
   localparam int PC_W_D       = `XLEN;

   function automatic int data_width(input int uuid_w, input int nw_w,
                                     input int thread_cnt, input int pc_w);
      return uuid_w + nw_w + thread_cnt + pc_w;
   endfunction

   localparam int DATA_W_D  = data_width(UUID_W_D, NW_W_D, THREAD_CNT_D, PC_W_D);

   localparam int PC_OFF    = 0;
   localparam int TMASK_OFF = PC_OFF + PC_W_D;
   localparam int WID_OFF   = TMASK_OFF + THREAD_CNT_D;
   localparam int UUID_OFF  = WID_OFF + NW_W_D;

   typedef struct packed {
      logic [UUID_W_D-1:0]     uuid;
      logic [NW_W_D-1:0]       wid;
      logic [THREAD_CNT_D-1:0] tmask;
      logic [PC_W_D-1:0]       pc;
   } sched_t;

   function automatic logic [DATA_W_D-1:0] pack_sched(input sched_t s);
      return {s.uuid, s.wid, s.tmask, s.pc};
   endfunction

   function automatic sched_t unpack_sched(input logic [DATA_W_D-1:0] d);
      sched_t s;
      s.uuid  = d[UUID_OFF  +: UUID_W_D];
      s.wid   = d[WID_OFF   +: NW_W_D];
      s.tmask = d[TMASK_OFF +: THREAD_CNT_D];
      s.pc    = d[PC_OFF    +: PC_W_D];
      return s;
   endfunction

endpackage

// File: rtl/vx_sched_fifo.sv
// Per-channel FIFO queue: registered full/valid flags, head visible combinationally.
module vx_sched_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign valid_o = (wr_ptr_q != rd_ptr_q);
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && valid_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/vx_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted channel.
module vx_sched_rr_arbiter #(
   parameter int NUM_INPUTS = 4,
   parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_INPUTS-1:0] req_i,
   input  logic                  en_i,
   output logic [NUM_INPUTS-1:0] gnt_oh_o,
   output logic [SEL_W-1:0]      gnt_idx_o,
   output logic                  gnt_vld_o
);

   logic [SEL_W-1:0] last_q, last_d;
   logic [SEL_W-1:0] cand;
   logic             found;

   always_comb begin
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         cand = SEL_W'((32'(last_q) + 32'(k)) % 32'(NUM_INPUTS));
         if (!found && req_i[cand]) begin
            found     = 1'b1;
            gnt_idx_o = cand;
         end
      end
      if (found) begin
         gnt_oh_o[gnt_idx_o] = 1'b1;
      end
      gnt_vld_o = found && en_i;
      last_d    = gnt_vld_o ? gnt_idx_o : last_q;
   end

   // Reset points at the last channel so channel 0 wins the first grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= SEL_W'(NUM_INPUTS - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/vx_schedule_arb.sv
// Multi-channel warp-schedule arbiter: per-channel FIFOs, zero-tmask discard with
// saturating drop counter, round-robin merge into one registered output slot.
module vx_schedule_arb
   import vx_sched_pkg::*;
#(
   parameter  int NUM_INPUTS = 4,
   parameter  int THREAD_CNT = THREAD_CNT_D,
   parameter  int UUID_W     = UUID_W_D,
   parameter  int NW_W       = NW_W_D,
   parameter  int PC_W       = PC_W_D,
   parameter  int DEPTH      = 2,
   parameter  int CNT_W      = 16,
   localparam int DATA_W     = data_width(UUID_W, NW_W, THREAD_CNT, PC_W),
   localparam int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_INPUTS-1:0]        in_valid,
   input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
   output logic [NUM_INPUTS-1:0]        in_ready,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_data,
   output logic [SEL_W-1:0]             out_sel,
   input  logic                         out_ready,
   output logic [CNT_W-1:0]             drop_count
);

   logic [DATA_W-1:0]     head_data [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] head_vld;
   logic [NUM_INPUTS-1:0] fifo_full;
   logic [NUM_INPUTS-1:0] tmask_nz;
   logic [NUM_INPUTS-1:0] drop_vec;
   logic [NUM_INPUTS-1:0] elig;
   logic [NUM_INPUTS-1:0] pop;
   logic [NUM_INPUTS-1:0] gnt_oh;
   logic [SEL_W-1:0]      gnt_idx;
   logic                  gnt_vld;
   logic                  slot_free;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_W-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0]      out_sel_q, out_sel_d;
   logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
   logic [CNT_W:0]        ndrop;
   logic [CNT_W:0]        cnt_sum;

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
      vx_sched_fifo #(
         .WIDTH (DATA_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .push_i  (in_valid[i]),
         .data_i  (in_data[i*DATA_W +: DATA_W]),
         .pop_i   (pop[i]),
         .full_o  (fifo_full[i]),
         .valid_o (head_vld[i]),
         .data_o  (head_data[i])
      );
      assign tmask_nz[i] = |head_data[i][PC_W +: THREAD_CNT];
   end

   assign in_ready  = ~fifo_full;
   assign drop_vec  = head_vld & ~tmask_nz;
   assign elig      = head_vld & tmask_nz;
   assign slot_free = !out_valid_q || out_ready;

   vx_sched_rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS),
      .SEL_W      (SEL_W)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_i     (elig),
      .en_i      (slot_free),
      .gnt_oh_o  (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   // Zero-mask heads leave every cycle, independent of output backpressure.
   assign pop = drop_vec | (gnt_vld ? gnt_oh : '0);

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (gnt_vld) begin
         out_valid_d = 1'b1;
         out_data_d  = head_data[gnt_idx];
         out_sel_d   = gnt_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      ndrop = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         ndrop = ndrop + (CNT_W+1)'(drop_vec[i]);
      end
      cnt_sum    = {1'b0, drop_cnt_q} + ndrop;
      drop_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_sel    = out_sel_q;
   assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_vx_schedule_arb.sv
// Bench for vx_schedule_arb: directed scenarios plus random traffic against a queue model.
module tb_vx_schedule_arb;
   import vx_sched_pkg::*;

   localparam int NI = 4;
   localparam int DP = 2;
   localparam int DW = DATA_W_D;

   logic               clk = 1'b0;
   logic               reset;
   logic [NI-1:0]      in_valid;
   logic [NI*DW-1:0]   in_data;
   logic [NI-1:0]      in_ready;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   logic [1:0]         out_sel;
   logic               out_ready;
   logic [15:0]        drop_count;

   logic [NI-1:0]      s_in_ready;
   logic               s_out_valid;
   logic [DW-1:0]      s_out_data;
   logic [1:0]         s_out_sel;
   logic [3:0]         s_drop;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic [DW-1:0] mq [NI][DP];
   int            mn [NI];
   logic          m_ov;
   logic [DW-1:0] m_od;
   int            m_os, m_last, m_cnt;

   always #5 clk = ~clk;

   vx_schedule_arb #(.NUM_INPUTS(NI), .DEPTH(DP), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_sel(out_sel), .out_ready(out_ready), .drop_count(drop_count));

   vx_schedule_arb #(.NUM_INPUTS(NI), .DEPTH(DP), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
      .out_sel(s_out_sel), .out_ready(out_ready), .drop_count(s_drop));

   function automatic logic [DW-1:0] mk(input logic [31:0] u, input logic [1:0] w,
                                        input logic [3:0] tm, input logic [31:0] pc);
      sched_t s;
      s       = '0;
      s.uuid  = {12'h0, u};
      s.wid   = w;
      s.tmask = tm;
      s.pc    = pc;
      return pack_sched(s);
   endfunction

   task automatic mpop(input int i);
      for (int j = 0; j < DP-1; j++) mq[i][j] = mq[i][j+1];
      mn[i]--;
   endtask

   // One clock of the arbiter's behaviour, from the current input values.
   task automatic model_step();
      logic [NI-1:0] rdy;
      logic [NI-1:0] el;
      int g;
      if (reset) begin
         for (int i = 0; i < NI; i++) mn[i] = 0;
         m_ov = 1'b0; m_od = '0; m_os = 0; m_last = NI-1; m_cnt = 0;
         return;
      end
      el = '0;
      for (int i = 0; i < NI; i++) rdy[i] = (mn[i] < DP);
      for (int i = 0; i < NI; i++) begin
         if (mn[i] > 0) begin
            if (mq[i][0][TMASK_OFF +: THREAD_CNT_D] == '0) begin
               mpop(i); m_cnt++;
            end else el[i] = 1'b1;
         end
      end
      if (!m_ov || out_ready) begin
         g = -1;
         for (int k = 1; k <= NI; k++)
            if (g < 0 && el[(m_last + k) % NI]) g = (m_last + k) % NI;
         if (g >= 0) begin
            m_ov = 1'b1; m_od = mq[g][0]; m_os = g; m_last = g; mpop(g);
         end else m_ov = 1'b0;
      end
      for (int i = 0; i < NI; i++)
         if (in_valid[i] && rdy[i]) begin
            mq[i][mn[i]] = in_data[i*DW +: DW]; mn[i]++;
         end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      vectors++; if (out_sel !== 2'd0) begin miscompares++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
      vectors++; if (drop_count !== 16'd0 || s_drop !== 4'd0) begin miscompares++; $display("FAIL reset_drop: got %0d/%0d want 0/0", drop_count, s_drop); end
      vectors++; if (in_ready !== 4'hf) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1111", in_ready); end
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      do_reset();
      d = mk(32'd5, 2'd1, 4'b1111, 32'h8000_0000);
      in_valid = 4'b0100; in_data[2*DW +: DW] = d;
      cyc();
      in_valid = '0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early: got %0b want 0", out_valid); end
      cyc();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0b want 1", out_valid); end
      vectors++; if (out_sel !== 2'd2) begin miscompares++; $display("FAIL single_sel: got %0d want 2", out_sel); end
      vectors++; if (out_data !== d) begin miscompares++; $display("FAIL single_data: got %h want %h", out_data, d); end
      cyc();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: got %0b want 0", out_valid); end
   endtask

   task automatic test_fairness();
      do_reset();
      in_valid = 4'hf;
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < NI; i++) in_data[i*DW +: DW] = mk(32'(100 + k), 2'(i), 4'b0101, 32'(i * 16 + k));
         cyc();
         if (k >= 1) begin
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fair_valid[%0d]: got %0b want 1", k, out_valid); end
            vectors++; if (out_sel !== 2'((k - 1) % 4)) begin miscompares++; $display("FAIL fair_sel[%0d]: got %0d want %0d", k, out_sel, (k - 1) % 4); end
            vectors++; if (out_data !== m_od) begin miscompares++; $display("FAIL fair_data[%0d]: got %h want %h", k, out_data, m_od); end
         end
      end
      in_valid = '0;
   endtask

   task automatic test_drop();
      logic [DW-1:0] d1;
      do_reset();
      d1 = mk(32'd22, 2'd3, 4'b0011, 32'h1234);
      in_valid = 4'b0010; in_data[1*DW +: DW] = mk(32'd21, 2'd3, 4'b0000, 32'h1230);
      cyc();
      in_data[1*DW +: DW] = d1;
      cyc();
      in_valid = '0;
      vectors++; if (drop_count !== 16'd1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_first: got cnt %0d valid %0b want 1 0", drop_count, out_valid); end
      cyc();
      vectors++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== d1) begin miscompares++; $display("FAIL drop_survivor: got %0b %0d %h want 1 1 %h", out_valid, out_sel, out_data, d1); end
      in_valid = 4'b1001;
      in_data[0*DW +: DW] = mk(32'd30, 2'd0, 4'b0000, 32'h40);
      in_data[3*DW +: DW] = mk(32'd33, 2'd3, 4'b0000, 32'h44);
      cyc();
      in_valid = '0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_noforward: got %0b want 0", out_valid); end
      cyc();
      vectors++; if (drop_count !== 16'd3 || s_drop !== 4'd3) begin miscompares++; $display("FAIL drop_pair: got %0d/%0d want 3/3", drop_count, s_drop); end
      cyc();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got %0b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] e [3];
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         e[k] = mk(32'(200 + k), 2'd0, 4'b1000, 32'(32'h100 + k * 4));
         in_valid = 4'b0001; in_data[0*DW +: DW] = e[k];
         cyc();
      end
      in_valid = '0;
      for (int k = 0; k < 3; k++) begin
         vectors++; if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %0b want 0", k, in_ready[0]); end
         vectors++; if (out_valid !== 1'b1 || out_data !== e[0]) begin miscompares++; $display("FAIL bp_hold[%0d]: got %0b %h want 1 %h", k, out_valid, out_data, e[0]); end
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      vectors++; if (out_valid !== 1'b1 || out_data !== e[1]) begin miscompares++; $display("FAIL bp_second: got %0b %h want 1 %h", out_valid, out_data, e[1]); end
      vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL bp_reopen: got %0b want 1", in_ready[0]); end
      cyc();
      vectors++; if (out_valid !== 1'b1 || out_data !== e[2]) begin miscompares++; $display("FAIL bp_third: got %0b %h want 1 %h", out_valid, out_data, e[2]); end
      cyc();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
   endtask

   task automatic test_saturation();
      do_reset();
      in_valid = 4'b0001;
      for (int k = 0; k < 20; k++) begin
         in_data[0*DW +: DW] = mk(32'(300 + k), 2'd0, 4'b0000, 32'(k));
         cyc();
         vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL sat_ready[%0d]: got %0b want 1", k, in_ready[0]); end
      end
      in_valid = '0;
      cyc(); cyc();
      vectors++; if (s_drop !== 4'd15) begin miscompares++; $display("FAIL sat_cnt4: got %0d want 15", s_drop); end
      vectors++; if (drop_count !== 16'd20) begin miscompares++; $display("FAIL sat_cnt16: got %0d want 20", drop_count); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sat_noforward: got %0b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      in_valid = 4'hf;
      for (int i = 0; i < NI; i++) in_data[i*DW +: DW] = mk(32'(400 + i), 2'(i), (i == 0) ? 4'b0000 : 4'b1110, 32'(i));
      cyc();
      in_data[0*DW +: DW] = mk(32'd410, 2'd0, 4'b0110, 32'h10);
      for (int k = 0; k < 6; k++) cyc();
      vectors++; if (in_ready !== 4'h0 || out_valid !== 1'b1 || drop_count !== 16'd1) begin miscompares++; $display("FAIL rmid_pre: got %b %0b %0d want 0000 1 1", in_ready, out_valid, drop_count); end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      vectors++; if (out_valid !== 1'b0 || in_ready !== 4'hf) begin miscompares++; $display("FAIL rmid_clear: got %0b %b want 0 1111", out_valid, in_ready); end
      vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL rmid_drop: got %0d want 0", drop_count); end
      out_ready = 1'b1;
      cyc();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_stale: got %0b want 0", out_valid); end
      cyc();
      in_valid = '0;
      vectors++; if (out_valid !== 1'b1 || out_sel !== 2'd0) begin miscompares++; $display("FAIL rmid_first: got %0b %0d want 1 0", out_valid, out_sel); end
      cyc(); cyc(); cyc(); cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
   endtask

   task automatic test_random();
      logic [NI-1:0] exp_rdy;
      logic [3:0]    tm;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NI; i++) begin
            tm = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            in_data[i*DW +: DW] = mk($urandom, 2'($urandom_range(0, 3)), tm, $urandom);
            in_valid[i] = ($urandom_range(0, 99) < 55);
         end
         out_ready = ($urandom_range(0, 99) < 70);
         cyc();
         for (int i = 0; i < NI; i++) exp_rdy[i] = (mn[i] < DP);
         vectors++; if (out_valid !== m_ov) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", k, out_valid, m_ov); end
         if (m_ov) begin
            vectors++; if (out_data !== m_od || out_sel !== 2'(m_os)) begin miscompares++; $display("FAIL rnd_out[%0d]: got %0d %h want %0d %h", k, out_sel, out_data, m_os, m_od); end
         end
         vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, in_ready, exp_rdy); end
         vectors++; if (drop_count !== 16'(m_cnt > 65535 ? 65535 : m_cnt) || s_drop !== 4'(m_cnt > 15 ? 15 : m_cnt)) begin
            miscompares++; $display("FAIL rnd_drop[%0d]: got %0d/%0d want %0d", k, drop_count, s_drop, m_cnt);
         end
      end
      in_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_drop();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
